// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the weighted round-robin arbiter.
package rr_arb_pkg;

    localparam int DEF_NUM_OF_INPUT = 20;
    localparam int DEF_INPUT_NBITS  = 5;
    localparam int DEF_WT_NBITS     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pri_enc.sv
// Rotating priority encoder: first set req bit at or after base+1 (mod N), wrapping back to base.
module rr_pri_enc
    import rr_arb_pkg::*;
#(
    parameter int NUM_OF_INPUT = DEF_NUM_OF_INPUT,
    parameter int INPUT_NBITS  = DEF_INPUT_NBITS
) (
    input  logic [NUM_OF_INPUT-1:0] req,
    input  logic [INPUT_NBITS-1:0]  base,
    output logic                    found,
    output logic [INPUT_NBITS-1:0]  idx
);

    logic [2*NUM_OF_INPUT-1:0] dbl;
    logic [NUM_OF_INPUT-1:0]   rot;
    logic [INPUT_NBITS:0]      start;
    logic [INPUT_NBITS:0]      pos;
    logic [INPUT_NBITS-1:0]    off;

    always_comb begin
        // base+1 wraps to 0 explicitly so a non-power-of-two N never yields an out-of-range start
        start = (base == INPUT_NBITS'(NUM_OF_INPUT - 1)) ? '0 : {1'b0, base} + 1'b1;
        dbl   = {req, req};
        rot   = dbl[start +: NUM_OF_INPUT];
        found = |req;
        off   = '0;
        for (int k = NUM_OF_INPUT - 1; k >= 0; k--) begin
            if (rot[k]) off = INPUT_NBITS'(k);
        end
        pos = start + {1'b0, off};
        if (pos >= (INPUT_NBITS + 1)'(NUM_OF_INPUT)) pos = pos - (INPUT_NBITS + 1)'(NUM_OF_INPUT);
        idx = INPUT_NBITS'(pos);
    end

endmodule

// File: rtl/rr_arb_wt.sv
// Weighted round-robin arbiter: each grantee keeps the grant for up to its weight in
// consecutive en cycles (lock extends it), then the search resumes just past it.
module rr_arb_wt
    import rr_arb_pkg::*;
#(
    parameter int NUM_OF_INPUT = DEF_NUM_OF_INPUT,
    parameter int INPUT_NBITS  = DEF_INPUT_NBITS,
    parameter int WT_NBITS     = DEF_WT_NBITS
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_OF_INPUT-1:0]          req,
    input  logic [NUM_OF_INPUT*WT_NBITS-1:0] wt,
    input  logic                             en,
    input  logic                             lock,
    output logic [INPUT_NBITS-1:0]           sel,
    output logic                             gnt,
    output logic [NUM_OF_INPUT-1:0]          gnt_vec,
    output logic [WT_NBITS-1:0]              burst_cnt
);

    function automatic logic [WT_NBITS-1:0] eff_wt(input logic [WT_NBITS-1:0] w);
        return (w == '0) ? WT_NBITS'(1) : w;
    endfunction

    state_t                  state, state_nxt;
    logic [INPUT_NBITS-1:0]  sel_nxt, idx;
    logic [WT_NBITS-1:0]     cnt_nxt, cur_wt;
    logic [NUM_OF_INPUT-1:0] vec_nxt;
    logic                    found, keep;

    rr_pri_enc #(
        .NUM_OF_INPUT(NUM_OF_INPUT),
        .INPUT_NBITS (INPUT_NBITS)
    ) u_pri_enc (
        .req  (req),
        .base (sel),
        .found(found),
        .idx  (idx)
    );

    assign cur_wt = eff_wt(wt[sel*WT_NBITS +: WT_NBITS]);
    assign keep   = (state == GRANT) && req[sel];
    assign gnt    = (state == GRANT);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = burst_cnt;
        if (en) begin
            if (!found) begin
                state_nxt = IDLE;
            end else if (!(keep && lock)) begin
                if (keep && (burst_cnt < cur_wt)) begin
                    cnt_nxt = burst_cnt + 1'b1;
                end else begin
                    state_nxt = GRANT;
                    sel_nxt   = idx;
                    cnt_nxt   = WT_NBITS'(1);
                end
            end
        end
        vec_nxt = '0;
        if (state_nxt == GRANT) vec_nxt[sel_nxt] = 1'b1;
    end

    // register stage: all outputs come straight from flops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sel       <= INPUT_NBITS'(NUM_OF_INPUT - 1);
            burst_cnt <= '0;
            gnt_vec   <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            burst_cnt <= cnt_nxt;
            gnt_vec   <= vec_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb_wt.sv
// Self-checking bench: behavioural arbiter model, directed scenarios and random parameter sweep.
module tb_rr_arb_wt;

    localparam int N  = 20;
    localparam int IW = 5;
    localparam int WB = 4;

    typedef struct packed {
        int   sel;
        logic gnt;
        int   cnt;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn, en, lock;
    logic [N-1:0]    req;
    logic [N*WB-1:0] wt;
    logic [IW-1:0]   sel;
    logic            gnt;
    logic [N-1:0]    gnt_vec;
    logic [WB-1:0]   burst_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb_wt #(.NUM_OF_INPUT(N), .INPUT_NBITS(IW), .WT_NBITS(WB)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .wt(wt), .en(en), .lock(lock),
        .sel(sel), .gnt(gnt), .gnt_vec(gnt_vec), .burst_cnt(burst_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(input int n);
        mdl_t r;
        r.sel = n - 1;
        r.gnt = 1'b0;
        r.cnt = 0;
        return r;
    endfunction

    // One en=1 step of the arbitration rules, stated directly from the behaviour.
    function automatic mdl_t mdl_step(input mdl_t m, input int n, input logic [63:0] rq,
                                      input logic [255:0] w, input logic lk);
        mdl_t r;
        int   ew, c;
        bit   any, held, hit;
        r   = m;
        any = 0;
        for (int i = 0; i < n; i++) if (rq[i]) any = 1;
        ew = int'(w[m.sel*4 +: 4]);
        if (ew == 0) ew = 1;
        held = m.gnt && rq[m.sel];
        if (!any) begin
            r.gnt = 1'b0;
        end else if (held && lk) begin
            r = m;
        end else if (held && m.cnt < ew) begin
            r.cnt = m.cnt + 1;
        end else begin
            hit = 0;
            for (int k = 1; k <= n; k++) begin
                c = (m.sel + k) % n;
                if (!hit && rq[c]) begin
                    hit   = 1;
                    r.sel = c;
                end
            end
            r.gnt = 1'b1;
            r.cnt = 1;
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_vec(input mdl_t m);
        return m.gnt ? (64'd1 << m.sel) : 64'd0;
    endfunction

    mdl_t mm;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) mm <= mdl_reset(N);
        else if (en) mm <= mdl_step(mm, N, 64'(req), 256'(wt), lock);
    end

    always @(posedge clk) begin
        #1;
        check("mdl_sel", 64'(sel), 64'(mm.sel));
        check("mdl_gnt", 64'(gnt), 64'(mm.gnt));
        check("mdl_vec", 64'(gnt_vec), exp_vec(mm));
        check("mdl_cnt", 64'(burst_cnt), 64'(mm.cnt));
    end

    // Parameter sweep: independent instances with their own model and starvation tracking.
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SN  = (g == 0) ? 2 : ((g == 1) ? 5 : 64);
        localparam int SIW = $clog2(SN);

        logic             s_rstn, s_en, s_lock;
        logic [SN-1:0]    s_req;
        logic [SN*4-1:0]  s_wt;
        logic [SIW-1:0]   s_sel;
        logic             s_gnt;
        logic [SN-1:0]    s_vec;
        logic [3:0]       s_cnt;
        mdl_t             sm;
        int               wait_c[SN];
        int               max_wait = 0;
        bit               s_run = 0;
        bit               done = 0;

        rr_arb_wt #(.NUM_OF_INPUT(SN), .INPUT_NBITS(SIW), .WT_NBITS(4)) u_dut (
            .clk(clk), .rstn(s_rstn), .req(s_req), .wt(s_wt), .en(s_en), .lock(s_lock),
            .sel(s_sel), .gnt(s_gnt), .gnt_vec(s_vec), .burst_cnt(s_cnt)
        );

        always @(posedge clk or negedge s_rstn) begin
            if (!s_rstn) begin
                sm <= mdl_reset(SN);
                for (int i = 0; i < SN; i++) wait_c[i] <= 0;
            end else if (s_en) begin
                mdl_t nx;
                nx = mdl_step(sm, SN, 64'(s_req), 256'(s_wt), s_lock);
                sm <= nx;
                for (int i = 0; i < SN; i++) begin
                    if (!s_req[i] || (nx.gnt && nx.sel == i)) wait_c[i] <= 0;
                    else if (!s_lock) wait_c[i] <= wait_c[i] + 1;
                end
            end
        end

        always @(posedge clk) begin
            #1;
            if (s_run) begin
                check("sw_sel", 64'(s_sel), 64'(sm.sel));
                check("sw_gnt", 64'(s_gnt), 64'(sm.gnt));
                check("sw_vec", 64'(s_vec), exp_vec(sm));
                check("sw_cnt", 64'(s_cnt), 64'(sm.cnt));
                check("sw_sel_range", 64'(int'(s_sel) < SN), 64'd1);
                check("sw_onehot0", 64'($onehot0(s_vec)), 64'd1);
                for (int i = 0; i < SN; i++) if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
        end

        initial begin
            s_rstn = 1'b0; s_en = 1'b0; s_lock = 1'b0;
            s_req  = SN'({$urandom, $urandom});
            for (int i = 0; i < SN; i++) s_wt[i*4 +: 4] = 4'($urandom);
            s_run = 1;
            repeat (2) @(posedge clk);
            #1;
            s_rstn = 1'b1;
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < SN; i++) if ($urandom_range(0, 7) == 0) s_req[i] = ~s_req[i];
                if ($urandom_range(0, 31) == 0)
                    for (int i = 0; i < SN; i++) s_wt[i*4 +: 4] = 4'($urandom);
                s_lock = ($urandom_range(0, 7) == 0);
                s_en   = ($urandom_range(0, 7) != 0);
                @(posedge clk);
                #2;
            end
            s_run = 0;
            check("sw_starvation", 64'(max_wait <= SN * 16), 64'd1);
            done = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b0; lock = 1'b0; req = '0;
        tick();
        check("lit_rst_sel", 64'(sel), 64'(N - 1));
        check("lit_rst_gnt", 64'(gnt), 64'd0);
        check("lit_rst_vec", 64'(gnt_vec), 64'd0);
        check("lit_rst_cnt", 64'(burst_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic set_all_wt(input logic [3:0] w);
        for (int i = 0; i < N; i++) wt[i*WB +: WB] = w;
    endtask

    int exp_s[8];
    int exp_c[8];
    bit sw_all;

    initial begin
        rstn = 1'b0; en = 1'b0; lock = 1'b0; req = '0; wt = '0;

        // first grant after reset searches from index 0
        do_reset();
        set_all_wt(4'd1);
        req = 20'h00001; en = 1'b1;
        tick();
        check("lit_first_sel", 64'(sel), 64'd0);
        check("lit_first_gnt", 64'(gnt), 64'd1);
        check("lit_first_vec", 64'(gnt_vec), 64'h1);
        check("lit_first_cnt", 64'(burst_cnt), 64'd1);

        // fairness and wrap
        do_reset();
        set_all_wt(4'd1);
        req = '1; en = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick();
            check("lit_fair_sel", 64'(sel), 64'(i % N));
        end

        // weighting 3 vs 1
        do_reset();
        wt = '0;
        wt[3*WB +: WB] = 4'd3;
        wt[7*WB +: WB] = 4'd1;
        req = (20'd1 << 3) | (20'd1 << 7); en = 1'b1;
        exp_s = '{3, 3, 3, 7, 3, 3, 3, 7};
        exp_c = '{1, 2, 3, 1, 1, 2, 3, 1};
        for (int i = 0; i < 8; i++) begin
            tick();
            check("lit_wt_sel", 64'(sel), 64'(exp_s[i]));
            check("lit_wt_cnt", 64'(burst_cnt), 64'(exp_c[i]));
        end

        // zero weight behaves as one
        wt[3*WB +: WB] = 4'd0;
        do_reset();
        req = (20'd1 << 3) | (20'd1 << 7); en = 1'b1;
        exp_s = '{3, 7, 3, 7, 3, 7, 3, 7};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lit_wt0_sel", 64'(sel), 64'(exp_s[i]));
            check("lit_wt0_cnt", 64'(burst_cnt), 64'd1);
        end

        // lock holds the grant beyond its weight
        do_reset();
        set_all_wt(4'd1);
        req = (20'd1 << 5) | (20'd1 << 9); en = 1'b1;
        tick();
        check("lit_lock_pre", 64'(sel), 64'd5);
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lit_lock_sel", 64'(sel), 64'd5);
            check("lit_lock_cnt", 64'(burst_cnt), 64'd1);
        end
        lock = 1'b0;
        tick();
        check("lit_unlock_sel", 64'(sel), 64'd9);

        // drop mid-burst, go idle, freeze with en=0
        do_reset();
        set_all_wt(4'd4);
        req = (20'd1 << 2) | (20'd1 << 6); en = 1'b1;
        tick();
        tick();
        check("lit_drop_pre_cnt", 64'(burst_cnt), 64'd2);
        req = 20'd1 << 6;
        tick();
        check("lit_drop_sel", 64'(sel), 64'd6);
        check("lit_drop_cnt", 64'(burst_cnt), 64'd1);
        req = '0;
        tick();
        check("lit_idle_gnt", 64'(gnt), 64'd0);
        check("lit_idle_sel", 64'(sel), 64'd6);
        check("lit_idle_vec", 64'(gnt_vec), 64'd0);
        for (int i = 0; i < 4; i++) begin
            en = 1'b0;
            req = N'($urandom);
            tick();
            check("lit_frz_gnt", 64'(gnt), 64'd0);
            check("lit_frz_sel", 64'(sel), 64'd6);
        end
        en = 1'b1; req = 20'd1 << 3;
        tick();
        check("lit_wrap_sel", 64'(sel), 64'd3);
        en = 1'b0; req = 20'd1 << 4;
        repeat (3) tick();
        check("lit_frz2_sel", 64'(sel), 64'd3);
        check("lit_frz2_gnt", 64'(gnt), 64'd1);
        en = 1'b1;
        tick();
        check("lit_after_frz_sel", 64'(sel), 64'd4);

        // sole requester is re-granted with a fresh burst
        do_reset();
        set_all_wt(4'd1);
        req = 20'd1 << 4; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_sole_sel", 64'(sel), 64'd4);
            check("lit_sole_cnt", 64'(burst_cnt), 64'd1);
        end

        // reset mid-burst abandons the grant without a clock
        do_reset();
        wt[1*WB +: WB] = 4'd8;
        req = 20'd1 << 1; en = 1'b1;
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("lit_async_sel", 64'(sel), 64'(N - 1));
        check("lit_async_gnt", 64'(gnt), 64'd0);
        check("lit_async_cnt", 64'(burst_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("lit_post_rst_sel", 64'(sel), 64'd1);
        check("lit_post_rst_cnt", 64'(burst_cnt), 64'd1);

        // randomized traffic on the default-size instance
        for (int c = 0; c < 600; c++) begin
            req  = N'($urandom) & (($urandom_range(0, 3) == 0) ? '1 : N'($urandom));
            if ($urandom_range(0, 15) == 0) for (int i = 0; i < N; i++) wt[i*WB +: WB] = 4'($urandom);
            lock = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 7) != 0);
            tick();
        end

        sw_all = 0;
        for (int t = 0; t < 20000 && !sw_all; t++) begin
            @(posedge clk);
            sw_all = g_sw[0].done && g_sw[1].done && g_sw[2].done;
        end
        check("sweep_done", 64'(sw_all), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
